// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed word UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state and the even-parity helper is used.
package fifo_uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div and flags the last cycle of each bit period.
// The divisor is captured on load so later changes on div are ignored mid-word.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_reg;

    always_ff @(posedge clock) begin
        if (!sclr) begin
            count   <= '0;
            div_reg <= '0;
        end else if (load) begin
            count   <= '0;
            div_reg <= div;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

    assign tick = (count == div_reg);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops 32-bit words from a show-ahead FIFO and sends them as four UART bytes, LSB byte first.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit to every byte.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_q,
    output logic             fifo_rdreq,
    input  logic [DIV_W-1:0] baud_div,
    output logic             txd,
    output logic             busy,
    output logic             word_done
);

    tx_state_t   state;
    tx_state_t   state_d;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_d;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_d;
    logic [31:0] word_reg;
    logic [31:0] word_d;
    logic        tick;
    logic        pop;
    logic        txd_d;

    // A pop happens from IDLE or on the very last cycle of a word, so words chain with no gap.
    assign pop = sclr && !fifo_empty &&
                 (state == IDLE || (state == STOP && byte_idx == LAST_BYTE && tick));

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clock  (clock),
        .sclr   (sclr),
        .load   (pop),
        .enable (state != IDLE),
        .div    (baud_div),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (!sclr) begin
            state    <= IDLE;
            byte_idx <= '0;
            bit_idx  <= '0;
            word_reg <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_d;
            byte_idx <= byte_d;
            bit_idx  <= bit_d;
            word_reg <= word_d;
            txd      <= txd_d;
        end
    end

    always_comb begin
        state_d = state;
        byte_d  = byte_idx;
        bit_d   = bit_idx;
        word_d  = pop ? fifo_q : word_reg;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (byte_idx != LAST_BYTE) begin
                        byte_d  = byte_idx + 2'd1;
                        state_d = START;
                    end else if (pop) begin
                        byte_d  = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from the upcoming bit so the line changes on the edge that enters each bit.
    always_comb begin
        fifo_rdreq = pop;
        busy       = (state != IDLE);
        word_done  = (state == STOP) && (byte_idx == LAST_BYTE) && tick;
        case (state_d)
            IDLE:   txd_d = 1'b1;
            START:  txd_d = 1'b0;
            DATA:   txd_d = word_d[{byte_d, bit_d}];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: txd_d = even_parity(word_d[{byte_d, 3'b000} +: 8]);
`endif
            STOP:   txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized self-checking bench for fifo_uart_tx against a per-cycle bit-schedule model.
// Honors FIFO_UART_TX_PARITY_EN for the 11-bit-per-byte frame.
module tb_fifo_uart_tx;

    localparam int DIV_W = 16;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int BPB            = 11;
    localparam int WORD_CYC_DIV3  = 176;
    localparam int WORD_CYC_DIV0  = 44;
`else
    localparam int BPB            = 10;
    localparam int WORD_CYC_DIV3  = 160;
    localparam int WORD_CYC_DIV0  = 40;
`endif

    logic             clock = 1'b0;
    logic             sclr;
    logic             fifo_empty;
    logic [31:0]      fifo_q;
    logic             fifo_rdreq;
    logic [DIV_W-1:0] baud_div;
    logic             txd;
    logic             busy;
    logic             word_done;

    always #5 clock = ~clock;

    fifo_uart_tx #(.DIV_W(DIV_W)) dut (
        .clock      (clock),
        .sclr       (sclr),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .baud_div   (baud_div),
        .txd        (txd),
        .busy       (busy),
        .word_done  (word_done)
    );

    // Upstream FIFO contents and the expected line schedule: one {word_done, txd} entry per cycle.
    logic [31:0] fifo_mem[$];
    logic [1:0]  sched[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic        txd_trace[$];
    int          rd_cycles[$];
    int          busy_count;
    int          done_count;
    int          txd_low_count;
    logic        last_busy;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic appendWord(input logic [31:0] w, input int div);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            logic       frame[$];
            by = w[8*b +: 8];
            frame.push_back(1'b0);
            for (int i = 0; i < 8; i++) frame.push_back(by[i]);
`ifdef FIFO_UART_TX_PARITY_EN
            frame.push_back(^by);
`endif
            frame.push_back(1'b1);
            foreach (frame[k])
                for (int r = 0; r <= div; r++) sched.push_back({1'b0, frame[k]});
        end
        sched[sched.size()-1] = {1'b1, sched[sched.size()-1][0]};
    endtask

    task automatic resetTrace();
        txd_trace.delete();
        rd_cycles.delete();
        busy_count = 0;
        done_count = 0;
        txd_low_count = 0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic applyStimulus(input logic sclr_v, input int div_v);
        logic exp_rd;
        logic rd_seen;
        logic exp_txd;
        logic exp_done;
        @(negedge clock);
        sclr       = sclr_v;
        baud_div   = DIV_W'(div_v);
        fifo_empty = (fifo_mem.size() == 0);
        fifo_q     = fifo_empty ? $urandom : fifo_mem[0];
        #1;
        exp_rd   = sclr_v && !fifo_empty && (sched.size() <= 1);
        exp_txd  = (sched.size() > 0) ? sched[0][0] : 1'b1;
        exp_done = (sched.size() > 0) ? sched[0][1] : 1'b0;
        checkOutput("fifo_rdreq", 32'(fifo_rdreq), 32'(exp_rd));
        checkOutput("txd",        32'(txd),        32'(exp_txd));
        checkOutput("busy",       32'(busy),       32'(sched.size() > 0));
        checkOutput("word_done",  32'(word_done),  32'(exp_done));
        if (fifo_rdreq) rd_cycles.push_back(txd_trace.size());
        if (busy) busy_count++;
        if (word_done) done_count++;
        if (!txd) txd_low_count++;
        last_busy = busy;
        txd_trace.push_back(txd);
        rd_seen = fifo_rdreq;
        @(posedge clock);
        if (!sclr_v) begin
            sched.delete();
        end else begin
            if (sched.size() > 0) void'(sched.pop_front());
            if (exp_rd) appendWord(fifo_q, div_v);
        end
        if (rd_seen && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    endtask

    function automatic logic sampleBit(input int pop_idx, input int k, input int period);
        int idx;
        idx = pop_idx + 1 + k * period + period / 2;
        return (idx < txd_trace.size()) ? txd_trace[idx] : 1'bx;
    endfunction

    initial begin
        int          pidx;
        logic [31:0] decoded;
        int          diff;

        sclr       = 1'b0;
        fifo_empty = 1'b1;
        fifo_q     = '0;
        baud_div   = '0;
        @(posedge clock);

        // Reset state
        resetTrace();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3);
        checkOutput("reset_txd_last", 32'(txd_trace[txd_trace.size()-1]), 32'd1);
        checkOutput("reset_busy_cnt", 32'(busy_count), 32'd0);

        // Single word 0x44332211 at baud_div=3; divisor changes after the pop must not matter
        resetTrace();
        fifo_mem.push_back(32'h44332211);
        applyStimulus(1'b1, 3);
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, $urandom_range(0, 7));
        checkOutput("w1_pops", 32'(rd_cycles.size()), 32'd1);
        checkOutput("w1_busy_cycles", 32'(busy_count), 32'(WORD_CYC_DIV3));
        checkOutput("w1_word_done", 32'(done_count), 32'd1);
        pidx = (rd_cycles.size() > 0) ? rd_cycles[0] : 0;
        decoded = '0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                decoded[8*b + i] = sampleBit(pidx, b * BPB + 1 + i, 4);
        checkOutput("w1_bytes", decoded, 32'h44332211);
        checkOutput("w1_start_bit", 32'(sampleBit(pidx, 0, 4)), 32'd0);
        checkOutput("w1_stop_bit", 32'(sampleBit(pidx, BPB - 1, 4)), 32'd1);

        // FIFO empty for 1000 cycles
        resetTrace();
        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, $urandom_range(0, 15));
        checkOutput("idle_pops", 32'(rd_cycles.size()), 32'd0);
        checkOutput("idle_busy", 32'(busy_count), 32'd0);
        checkOutput("idle_txd_low", 32'(txd_low_count), 32'd0);

        // Two queued words at baud_div=0 go out back to back
        resetTrace();
        fifo_mem.push_back($urandom);
        fifo_mem.push_back($urandom);
        for (int i = 0; i < 120; i++) applyStimulus(1'b1, 0);
        checkOutput("b2b_pops", 32'(rd_cycles.size()), 32'd2);
        diff = (rd_cycles.size() >= 2) ? rd_cycles[1] - rd_cycles[0] : -1;
        checkOutput("b2b_pop_gap", 32'(diff), 32'(WORD_CYC_DIV0));
        checkOutput("b2b_busy", 32'(busy_count), 32'(2 * WORD_CYC_DIV0));

        // Reset in data bit 5 of byte 1 abandons the word
        resetTrace();
        fifo_mem.push_back(32'hA5C35A3C);
        for (int i = 0; i < 1 + (BPB + 6) * 4 + 1; i++) applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 3);
        checkOutput("rst_mid_txd", 32'(txd_trace[txd_trace.size()-1]), 32'd1);
        checkOutput("rst_mid_busy", 32'(last_busy), 32'd0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 3);
        checkOutput("rst_mid_pops", 32'(rd_cycles.size()), 32'd1);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity: word 0x00000007 at baud_div=1
        resetTrace();
        fifo_mem.push_back(32'h00000007);
        for (int i = 0; i < 120; i++) applyStimulus(1'b1, 1);
        checkOutput("par_busy", 32'(busy_count), 32'd88);
        pidx = (rd_cycles.size() > 0) ? rd_cycles[0] : 0;
        checkOutput("par_byte0", 32'(sampleBit(pidx, 9, 2)), 32'd1);
        for (int b = 1; b < 4; b++)
            checkOutput("par_byteN", 32'(sampleBit(pidx, b * BPB + 9, 2)), 32'd0);
`endif

        // Randomized traffic with changing divisors and occasional resets
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int w = 0; w < n; w++) fifo_mem.push_back($urandom);
            n = $urandom_range(20, 150);
            for (int c = 0; c < n; c++)
                applyStimulus(($urandom_range(0, 199) != 0), $urandom_range(0, 3));
        end
        for (int c = 0; c < 3000 && (fifo_mem.size() > 0 || sched.size() > 0); c++)
            applyStimulus(1'b1, $urandom_range(0, 3));
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 0);
        checkOutput("drain_empty", 32'(fifo_mem.size() + sched.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the bit-period divisor input.
REQ-002 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port sclr  input  1  synchronous, active-low reset; a low level sampled at a rising clock edge resets the block.
REQ-004 SHALL have port fifo_empty  input  1  upstream FIFO holds no word.
REQ-005 SHALL have port fifo_q  input  32  upstream FIFO head word; show-ahead, valid while fifo_empty=0.
REQ-006 SHALL have port fifo_rdreq  output  1  pop request to the upstream FIFO; one pop per cycle high.
REQ-007 SHALL have port baud_div  input  DIV_W  bit period minus one, in clock cycles.
REQ-008 SHALL have port txd  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  high while a word is being transmitted.
REQ-010 SHALL have port word_done  output  1  one-cycle pulse at the end of the last stop bit of each word.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive fifo_rdreq combinationally high when fifo_empty=0 and either (a) state=IDLE or (b) state=STOP, byte index=3 and the bit-period counter is at its last cycle.
REQ-013 SHALL latch fifo_q into a 32-bit shift register on every edge where fifo_rdreq=1, set byte index to 0, sample baud_div, and enter START.
REQ-014 SHALL never assert fifo_rdreq while fifo_empty=1, and SHALL never assert it more than once per word.
REQ-015 SHALL hold each bit for exactly baud_div+1 cycles, using the baud_div value sampled at word latch; baud_div=0 gives one cycle per bit.
REQ-016 SHALL send each word as 4 bytes, byte 0 = bits[7:0] first; each byte = start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
REQ-017 SHALL transition START->DATA after one bit period, DATA->PARITY (macro defined) or DATA->STOP after 8 bit periods, PARITY->STOP after one bit period.
REQ-018 SHALL, at the end of STOP: byte index<3 -> increment index, enter START; byte index=3 and fifo_empty=0 -> pop and enter START (no idle gap); byte index=3 and fifo_empty=1 -> enter IDLE.
REQ-019 SHALL pulse word_done for exactly the last cycle of the stop bit of byte 3.
REQ-020 SHALL drive txd=1 in IDLE; txd is registered and goes low on the cycle after the pop edge.
REQ-021 SHALL drive busy=1 whenever state!=IDLE.
REQ-022 SHALL ignore changes on baud_div and fifo_q between pops.

Reset
REQ-023 SHALL, when sclr=0 at an edge, enter IDLE with txd=1, fifo_rdreq=0, busy=0, word_done=0, counters and byte index=0.
REQ-024 SHALL, on reset mid-word, abandon the partial word without re-sending it; txd returns high on the next cycle.
REQ-025 SHALL hold fifo_rdreq=0 in every cycle where sclr=0.

Configuration
REQ-026 SHALL, with FIFO_UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) after each byte, giving 11 bits/byte.
REQ-027 SHALL, without FIFO_UART_TX_PARITY_EN, omit the PARITY state entirely, giving 10 bits/byte.

Structure
REQ-028 SHALL place the state encoding, BYTES_PER_WORD=4 and BITS_PER_BYTE=8 in shared package fifo_uart_pkg.
REQ-029 SHALL implement bit timing in one sub-module uart_baud_gen (counter, load, last-cycle tick); the rest stays in fifo_uart_tx.

Verification
REQ-030 SHALL cover: baud_div=3, one word 0x44332211 -> one fifo_rdreq pulse; txd carries bytes 0x11,0x22,0x33,0x44; busy high 160 cycles (no parity); word_done once.
REQ-031 SHALL cover: fifo_empty held 1 for 1000 cycles -> txd=1, fifo_rdreq=0, busy=0 throughout.
REQ-032 SHALL cover: two words queued, baud_div=0 -> pops exactly 40 cycles apart; txd has no idle cycle between words.
REQ-033 SHALL cover: sclr=0 in bit 5 of byte 1 -> next cycle txd=1, busy=0; after release with FIFO empty no further pop.
REQ-034 SHALL cover: FIFO_UART_TX_PARITY_EN defined, word 0x00000007, baud_div=1 -> byte 0 parity bit=1, other bytes parity 0; word lasts 88 cycles.
